// File: rtl/fx2_tx_writer.sv
// FX2LP slave-FIFO transmit engine: stream words into the EP6 IN FIFO.
// Owns SLWR/PKTEND/FIFOADDR and the FD drive enable while granted.
`timescale 1ns/1ps
module fx2_tx_writer #(
  parameter logic [1:0] FIFOADDR = 2'b10,
  parameter int PKT_WORDS = 256,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [15:0]      s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic             bus_req,
  input  logic             bus_gnt,
  input  logic             fx2_full_n,
  output logic             fx2_slwr_n,
  output logic             fx2_pktend_n,
  output logic [1:0]       fx2_fifoaddr,
  output logic [15:0]      fx2_fd_out,
  output logic             fx2_fd_oe,
  output logic [CNT_W-1:0] tx_count
);

  localparam int PW = $clog2(PKT_WORDS);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, REQ, SETUP, WRITE, PKTEND, RELEASE
  } state_t;

  state_t        state;
  logic [PW-1:0] pkt_cnt;
  logic [PW-1:0] cnt_inc;
  logic [TW-1:0] tmo;
  logic          acc;
  logic          lost;

  assign s_ready = (state == WRITE) && fx2_full_n && bus_gnt;
  assign acc     = s_valid && s_ready;
  assign lost    = !bus_gnt &&
                   (state inside {SETUP, WRITE, PKTEND, RELEASE});
  assign cnt_inc = (pkt_cnt == PW'(PKT_WORDS - 1)) ? '0
                 : pkt_cnt + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      bus_req      <= 1'b0;
      fx2_fd_oe    <= 1'b0;
      fx2_slwr_n   <= 1'b1;
      fx2_pktend_n <= 1'b1;
      fx2_fifoaddr <= FIFOADDR;
      fx2_fd_out   <= '0;
      tx_count     <= '0;
      pkt_cnt      <= '0;
      tmo          <= '0;
    end else begin
      fx2_fifoaddr <= FIFOADDR;
      fx2_slwr_n   <= 1'b1;
      fx2_pktend_n <= 1'b1;
      if (acc) begin
        fx2_slwr_n <= 1'b0;
        fx2_fd_out <= s_data;
        tx_count   <= tx_count + 1'b1;
      end
      if (lost) begin
        state     <= REQ;
        bus_req   <= 1'b1;
        fx2_fd_oe <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (s_valid) begin
              state   <= REQ;
              bus_req <= 1'b1;
            end
          end
          REQ: begin
            if (bus_gnt) begin
              state     <= SETUP;
              fx2_fd_oe <= 1'b1;
            end
          end
          SETUP: state <= WRITE;
          WRITE: begin
            if (acc) begin
              tmo     <= '0;
              pkt_cnt <= cnt_inc;
              if (s_last)
                state <= (cnt_inc == '0) ? RELEASE : PKTEND;
            end else if (!s_valid) begin
              if (pkt_cnt == '0) begin
                state     <= RELEASE;
                bus_req   <= 1'b0;
                fx2_fd_oe <= 1'b0;
              end else if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
                // no strobe pending, so the flush can go out at once
                state        <= PKTEND;
                fx2_pktend_n <= 1'b0;
                pkt_cnt      <= '0;
                tmo          <= '0;
              end else begin
                tmo <= tmo + 1'b1;
              end
            end
          end
          PKTEND: begin
            // first cycle may still carry the final strobe
            if (fx2_pktend_n) begin
              fx2_pktend_n <= 1'b0;
              pkt_cnt      <= '0;
            end else begin
              state     <= RELEASE;
              bus_req   <= 1'b0;
              fx2_fd_oe <= 1'b0;
            end
          end
          RELEASE: begin
            state     <= IDLE;
            bus_req   <= 1'b0;
            fx2_fd_oe <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fx2_tx_writer.sv
// Directed bench for fx2_tx_writer: framing, flow control,
// timeout flush, full-packet commit and async reset.
`timescale 1ns/1ps
module tb_fx2_tx_writer;

  localparam int TMO = 16;
  localparam int PKT = 256;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic        bus_req;
  logic        bus_gnt;
  logic        fx2_full_n = 1'b1;
  logic        fx2_slwr_n;
  logic        fx2_pktend_n;
  logic [1:0]  fx2_fifoaddr;
  logic [15:0] fx2_fd_out;
  logic        fx2_fd_oe;
  logic [23:0] tx_count;

  fx2_tx_writer #(
    .FIFOADDR(2'b10), .PKT_WORDS(PKT),
    .TIMEOUT_CYCLES(TMO), .CNT_W(24)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_ready(s_ready),
    .bus_req(bus_req), .bus_gnt(bus_gnt),
    .fx2_full_n(fx2_full_n),
    .fx2_slwr_n(fx2_slwr_n),
    .fx2_pktend_n(fx2_pktend_n),
    .fx2_fifoaddr(fx2_fifoaddr),
    .fx2_fd_out(fx2_fd_out),
    .fx2_fd_oe(fx2_fd_oe),
    .tx_count(tx_count)
  );

  always #5 clk = ~clk;

  // arbiter: grant follows request one cycle later
  always @(posedge clk or negedge reset_n)
    if (!reset_n) bus_gnt <= 1'b0;
    else          bus_gnt <= bus_req;

  int          n_chk = 0;
  int          n_fail = 0;
  int          ncyc = 0;
  logic [15:0] got[$];
  logic [15:0] exp_q[$];
  int          scyc[$];
  int          pkt_ends, pe_cyc, oe_rise, oe_fall;
  int          overlap, rdy_bad, oe_bad;
  logic        oe_prev = 1'b0;

  always @(negedge clk) begin
    if (!fx2_slwr_n) begin
      got.push_back(fx2_fd_out);
      scyc.push_back(ncyc);
      if (!fx2_fd_oe) oe_bad++;
    end
    if (!fx2_pktend_n) begin
      pkt_ends++;
      pe_cyc = ncyc;
    end
    if (!fx2_slwr_n && !fx2_pktend_n) overlap++;
    if (!fx2_full_n && s_ready) rdy_bad++;
    if (fx2_fd_oe && !oe_prev) oe_rise = ncyc;
    if (!fx2_fd_oe && oe_prev) oe_fall = ncyc;
    oe_prev = fx2_fd_oe;
    ncyc++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, obs, exp);
    end
  endtask

  task automatic clr();
    got.delete();
    exp_q.delete();
    scyc.delete();
    pkt_ends = 0; pe_cyc = -1;
    oe_rise = -1; oe_fall = -1;
    overlap = 0; rdy_bad = 0; oe_bad = 0;
  endtask

  function automatic int sc(input int i);
    return (i >= 0 && i < scyc.size()) ? scyc[i] : -1000;
  endfunction

  function automatic int last_sc();
    return sc(scyc.size() - 1);
  endfunction

  task automatic push(input logic [15:0] d, input logic l);
    int n;
    n = 0;
    s_data = d; s_valid = 1'b1; s_last = l;
    exp_q.push_back(d);
    @(negedge clk);
    while (!s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) chk("push_wait", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic settle();
    repeat (24) @(posedge clk);
    #1;
  endtask

  task automatic cmp_stream(input string tag);
    int n;
    chk({tag, "_nwords"}, got.size(), exp_q.size());
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_w%0d", tag, i), got[i], exp_q[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    clr();
    #12;
    chk("rst_slwr", fx2_slwr_n, 1);
    chk("rst_pktend", fx2_pktend_n, 1);
    chk("rst_oe", fx2_fd_oe, 0);
    chk("rst_req", bus_req, 0);
    chk("rst_ready", s_ready, 0);
    chk("rst_addr", fx2_fifoaddr, 2'b10);
    chk("rst_fd", fx2_fd_out, 0);
    chk("rst_cnt", tx_count, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clk); #1;

    // short message with s_last
    clr();
    push(16'h1111, 0); push(16'h2222, 0);
    push(16'h3333, 0); push(16'h4444, 1);
    settle();
    cmp_stream("t1");
    chk("t1_setup_gap", sc(0) - oe_rise, 2);
    chk("t1_consec", sc(3) - sc(0), 3);
    chk("t1_pktend_cyc", pe_cyc - last_sc(), 1);
    chk("t1_pktends", pkt_ends, 1);
    chk("t1_oe_fall", oe_fall - pe_cyc, 1);
    chk("t1_overlap", overlap, 0);
    chk("t1_count", tx_count, 4);
    chk("t1_req_off", bus_req, 0);

    // one full packet, no s_last: auto-commit
    clr();
    for (int i = 0; i < PKT; i++) push(16'hA000 + 16'(i), 0);
    settle();
    cmp_stream("t2");
    chk("t2_consec", last_sc() - sc(0), PKT - 1);
    chk("t2_pktends", pkt_ends, 0);
    chk("t2_oe_fall", oe_fall - last_sc(), 1);
    chk("t2_oe_bad", oe_bad, 0);
    chk("t2_count", tx_count, 4 + PKT);
    chk("t2_req_off", bus_req, 0);

    // FIFO full for 5 cycles after word 10
    clr();
    base = 4 + PKT;
    for (int i = 1; i <= 20; i++) begin
      push(16'hB000 + 16'(i), i == 20);
      if (i == 10) begin
        fx2_full_n = 1'b0;
        fork
          begin
            repeat (5) @(posedge clk);
            #1 fx2_full_n = 1'b1;
          end
        join_none
      end
    end
    settle();
    cmp_stream("t3");
    chk("t3_gap", sc(10) - sc(9), 6);
    chk("t3_rdy_full", rdy_bad, 0);
    chk("t3_pktends", pkt_ends, 1);
    chk("t3_overlap", overlap, 0);
    chk("t3_count", tx_count, base + 20);

    // partial packet flushed by idle timeout
    clr();
    base = base + 20;
    push(16'hC001, 0); push(16'hC002, 0); push(16'hC003, 0);
    repeat (TMO + 12) @(posedge clk); #1;
    cmp_stream("t4");
    chk("t4_timeout", pe_cyc - last_sc(), TMO);
    chk("t4_pktends", pkt_ends, 1);
    chk("t4_oe_fall", oe_fall - pe_cyc, 1);
    chk("t4_count", tx_count, base + 3);

    // s_last lands exactly on a full packet
    clr();
    base = base + 3;
    for (int i = 0; i < PKT; i++)
      push(16'hD000 + 16'(i), i == PKT - 1);
    settle();
    cmp_stream("t5");
    chk("t5_pktends", pkt_ends, 0);
    chk("t5_oe_fall", oe_fall - last_sc(), 1);
    chk("t5_count", tx_count, base + PKT);

    // async reset in the middle of a write burst
    s_data = 16'h5A5A; s_valid = 1'b1; s_last = 1'b0;
    repeat (8) @(posedge clk);
    #3;
    chk("t6_pre_slwr", fx2_slwr_n, 0);
    chk("t6_pre_oe", fx2_fd_oe, 1);
    reset_n = 1'b0;
    #1;
    chk("t6_slwr", fx2_slwr_n, 1);
    chk("t6_pktend", fx2_pktend_n, 1);
    chk("t6_oe", fx2_fd_oe, 0);
    chk("t6_req", bus_req, 0);
    chk("t6_ready", s_ready, 0);
    chk("t6_fd", fx2_fd_out, 0);
    chk("t6_count", tx_count, 0);
    s_valid = 1'b0;
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
